// File: rtl/calc_entry_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : calc_entry_seq_if                                                 |
// | Brief   : Key-event, ALU operand/result and display bundle for the sequencer |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface calc_entry_seq_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              key_valid;
  logic [4:0]        key_code;
  logic              key_ready;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [OP_W-1:0]   OpCode;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovfl;
  logic              alu_zero;
  logic              alu_neg;
  logic [DATA_W-1:0] result;
  logic [2:0]        flags;
  logic              res_valid;
  logic              done;
  logic              err;
  logic [2:0]        state;

  modport master (
    output key_valid, key_code, alu_res, alu_ovfl, alu_zero, alu_neg,
    input  key_ready, opA, opB, OpCode, result, flags, res_valid, done, err, state
  );

  modport slave (
    input  key_valid, key_code, alu_res, alu_ovfl, alu_zero, alu_neg,
    output key_ready, opA, opB, OpCode, result, flags, res_valid, done, err, state
  );
endinterface
`default_nettype wire

// File: rtl/calc_entry_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : calc_entry_seq                                                    |
// | Brief   : Keypad-to-ALU operand sequencer with result hold and chaining     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module calc_entry_seq #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  calc_entry_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    EXEC   = 3'd4,
    SHOW   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] C_OP_NOT = OP_W'(5);

  state_t            state_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] result_q;
  logic [OP_W-1:0]   opcode_q;
  logic [2:0]        flags_q;
  logic              done_q;
  logic              err_q;

  logic              w_ready;
  logic              w_take;
  logic              w_digit;
  logic              w_oper;
  logic              w_clr;
  logic              w_clear;
  logic [DATA_W-1:0] w_dval;
  logic [OP_W-1:0]   w_oval;

  assign w_ready = (state_q != EXEC);
  // Codes 0x1A-0x1F are swallowed by the handshake but never reach the FSM.
  assign w_take  = bus.key_valid && w_ready && (bus.key_code < 5'h1A);
  assign w_digit = ~bus.key_code[4];
  assign w_oper  = (bus.key_code[4:3] == 2'b10);
  assign w_clr   = (bus.key_code == 5'h19);
  assign w_dval  = DATA_W'(bus.key_code[3:0]);
  assign w_oval  = OP_W'(bus.key_code[2:0]);
  assign w_clear = (w_take && w_clr) || (state_q > SHOW);

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_take) begin
            if (w_digit) begin
              opa_q   <= w_dval;
              state_q <= GOT_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GOT_A: begin
          if (w_take) begin
            if (w_digit) begin
              opa_q <= w_dval;
            end else if (w_oper) begin
              opcode_q <= w_oval;
              if (w_oval == C_OP_NOT) begin
                opb_q   <= '0;
                state_q <= EXEC;
              end else begin
                state_q <= GOT_OP;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GOT_OP: begin
          if (w_take) begin
            if (w_oper) begin
              opcode_q <= w_oval;
            end else if (w_digit) begin
              opb_q   <= w_dval;
              state_q <= GOT_B;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GOT_B: begin
          if (w_take) begin
            if (w_digit) begin
              opb_q <= w_dval;
            end else if (w_oper) begin
              err_q <= 1'b1;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          result_q <= bus.alu_res;
          flags_q  <= {bus.alu_ovfl, bus.alu_zero, bus.alu_neg};
          done_q   <= 1'b1;
          state_q  <= SHOW;
        end
        SHOW: begin
          if (w_take) begin
            if (w_oper) begin
              // Chaining: the held result becomes the new first operand.
              opa_q    <= result_q;
              opcode_q <= w_oval;
              if (w_oval == C_OP_NOT) begin
                opb_q   <= '0;
                state_q <= EXEC;
              end else begin
                state_q <= GOT_OP;
              end
            end else if (w_digit) begin
              opa_q   <= w_dval;
              state_q <= GOT_A;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.key_ready = w_ready;
  assign bus.opA       = opa_q;
  assign bus.opB       = opb_q;
  assign bus.OpCode    = opcode_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.res_valid = (state_q == SHOW);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state     = state_q;

endmodule
`default_nettype wire
